// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
//
// Shared types and constants for the ALU operation sequencer.
//
//   seq_state_e : sequencer FSM states (IDLE, SETTLE, CAPTURE)
//   SEL_*       : selector encodings choosing which operand/config register
//                 a push-button load writes
//   ALU_W       : ALU data width
//   MODE_W      : ALU mode_select width
//
// Optional feature macro used by the sequencer: ALU_OP_SEQ_CHAIN_EN
// -----------------------------------------------------------------------------
package alu_seq_pkg;

   localparam int ALU_W  = 16;
   localparam int MODE_W = 4;

   // Selector encodings for the four loadable registers.
   localparam logic [1:0] SEL_SRC  = 2'b00;
   localparam logic [1:0] SEL_DST  = 2'b01;
   localparam logic [1:0] SEL_MODE = 2'b10;
   localparam logic [1:0] SEL_CIN  = 2'b11;

   // All four registers written at least once.
   localparam logic [3:0] ALL_LOADED = 4'hF;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      SETTLE  = 2'b01,
      CAPTURE = 2'b10
   } seq_state_e;

endpackage : alu_seq_pkg

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//
// Conditions one raw push-button input:
//   1. SYNC_STAGES-deep flip-flop synchroniser (button is asynchronous to clk)
//   2. debounce: the accepted level only follows the synchronised input after
//      DEBOUNCE_CYCLES consecutive samples that differ from the current level
//   3. rising-edge detect: one-clock pulse when the accepted level goes 0->1
//
// A button held down produces exactly one pulse; a release produces none.
//
// Ports
//   clk    in  1  system clock
//   rst_n  in  1  asynchronous active-low reset
//   raw    in  1  raw button level from the pin
//   pulse  out 1  registered one-clock pulse on accepted press
// -----------------------------------------------------------------------------
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int SYNC_STAGES     = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic pulse
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   synced;
   logic                   level;
   logic [CNT_W-1:0]       cnt;

   assign synced = sync_q[SYNC_STAGES-1];

   // NOTE: all state here is updated with non-blocking assignments so every
   // flop samples the pre-edge value of its neighbours; blocking assignments
   // would collapse the synchroniser chain into a single stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         level  <= 1'b0;
         cnt    <= '0;
         pulse  <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
         pulse  <= 1'b0;

         if (synced == level) begin
            // Input agrees with the accepted level: any bounce run is over.
            cnt <= '0;
         end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            // This is the DEBOUNCE_CYCLES-th consecutive differing sample.
            level <= synced;
            cnt   <= '0;
            pulse <= synced;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule : btn_debounce

// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
//
// Clocked controller that drives a combinational 16-bit ALU from board
// switches and two push buttons. The push button loads the switch value into
// the register picked by selector (SRC, DST, mode, carry-in); the start button
// runs an operation once all four registers have been loaded: the ALU inputs
// are held for SETTLE_CYCLES clocks, then result and carry are captured.
//
// Configuration macro: ALU_OP_SEQ_CHAIN_EN
//   defined     : CAPTURE also copies alu_cout into the carry-in register so
//                 consecutive starts chain multi-precision add/sub; a push with
//                 selector 11 still overrides it.
//   not defined : carry-in only changes on selector 11 pushes.
//
// Ports
//   clk           in   1   system clock
//   rst_n         in   1   asynchronous active-low reset
//   switches      in   16  operand / config value
//   selector      in   2   00 SRC, 01 DST, 10 mode (switches[3:0]),
//                          11 carry-in (switches[0])
//   push_button   in   1   raw button: load switches into selected register
//   start_button  in   1   raw button: run ALU and capture result
//   alu_a         out  16  to ALU a (SRC register)
//   alu_b         out  16  to ALU b (DST register)
//   alu_mode      out  4   to ALU mode_select
//   alu_cin       out  1   to ALU carry_in
//   alu_result    in   16  from ALU result
//   alu_cout      in   1   from ALU carry_out
//   result        out  16  captured result
//   carry_out     out  1   captured carry
//   result_valid  out  1   result/carry_out hold a completed operation
//   busy          out  1   operation in progress
//   loaded        out  4   bit i set once register for selector i written
//   start_err     out  1   sticky: start requested before all registers loaded
// -----------------------------------------------------------------------------
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int SYNC_STAGES     = 2,
   parameter int SETTLE_CYCLES   = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ALU_W-1:0]  switches,
   input  logic [1:0]        selector,
   input  logic              push_button,
   input  logic              start_button,
   output logic [ALU_W-1:0]  alu_a,
   output logic [ALU_W-1:0]  alu_b,
   output logic [MODE_W-1:0] alu_mode,
   output logic              alu_cin,
   input  logic [ALU_W-1:0]  alu_result,
   input  logic              alu_cout,
   output logic [ALU_W-1:0]  result,
   output logic              carry_out,
   output logic              result_valid,
   output logic              busy,
   output logic [3:0]        loaded,
   output logic              start_err
);

   localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   logic push_pulse;
   logic start_pulse;

   seq_state_e          state;
   logic [SETTLE_W-1:0] settle_cnt;

   logic [ALU_W-1:0]  src_q;
   logic [ALU_W-1:0]  dst_q;
   logic [MODE_W-1:0] mode_q;
   logic              cin_q;

   // ---------------------------------------------------------------------------
   // Button conditioning
   // ---------------------------------------------------------------------------
   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
   ) u_push_db (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (push_button),
      .pulse (push_pulse)
   );

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
   ) u_start_db (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (start_button),
      .pulse (start_pulse)
   );

   // The ALU sees the registers directly. Registers only change in IDLE, so
   // the ALU inputs are stable for the whole SETTLE/CAPTURE window.
   assign alu_a    = src_q;
   assign alu_b    = dst_q;
   assign alu_mode = mode_q;
   assign alu_cin  = cin_q;

   // ---------------------------------------------------------------------------
   // Sequencer FSM with registered outputs
   // ---------------------------------------------------------------------------
   // NOTE: the operand registers are a handful of flops, not a RAM, so they
   // take the asynchronous reset like everything else; that is what makes the
   // ALU inputs read back as 0 straight out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         settle_cnt   <= '0;
         src_q        <= '0;
         dst_q        <= '0;
         mode_q       <= '0;
         cin_q        <= 1'b0;
         result       <= '0;
         carry_out    <= 1'b0;
         result_valid <= 1'b0;
         busy         <= 1'b0;
         loaded       <= '0;
         start_err    <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               // A push takes priority: a start in the same clock is dropped.
               if (push_pulse) begin
                  case (selector)
                     SEL_SRC:  src_q  <= switches;
                     SEL_DST:  dst_q  <= switches;
                     SEL_MODE: mode_q <= switches[MODE_W-1:0];
                     SEL_CIN:  cin_q  <= switches[0];
                  endcase
                  loaded[selector] <= 1'b1;
                  result_valid     <= 1'b0;
                  start_err        <= 1'b0;
               end else if (start_pulse) begin
                  if (loaded == ALL_LOADED) begin
                     state      <= SETTLE;
                     busy       <= 1'b1;
                     settle_cnt <= '0;
                  end else begin
                     start_err <= 1'b1;
                  end
               end
            end

            SETTLE: begin
               // Pulses arriving here are simply ignored (not queued).
               if (settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1)) begin
                  state <= CAPTURE;
               end else begin
                  settle_cnt <= settle_cnt + 1'b1;
               end
            end

            CAPTURE: begin
               result       <= alu_result;
               carry_out    <= alu_cout;
               result_valid <= 1'b1;
               busy         <= 1'b0;
`ifdef ALU_OP_SEQ_CHAIN_EN
               // Feed the carry forward for multi-precision chains.
               cin_q        <= alu_cout;
`endif
               state        <= IDLE;
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule : alu_op_sequencer

// File: tb/tb_alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_op_sequencer
//
// Self-checking bench for alu_op_sequencer with DEBOUNCE_CYCLES=4,
// SYNC_STAGES=2, SETTLE_CYCLES=8 and an ALU stub computing a+b+cin.
// A reference model tracks the architectural registers from the button
// operations the bench performs and predicts every output.
// -----------------------------------------------------------------------------
module tb_alu_op_sequencer;

   localparam int DEB    = 4;
   localparam int SYNC   = 2;
   localparam int SETTLE = 8;

`ifdef ALU_OP_SEQ_CHAIN_EN
   localparam bit CHAIN = 1'b1;
`else
   localparam bit CHAIN = 1'b0;
`endif

   localparam logic [1:0] S_SRC  = 2'd0;
   localparam logic [1:0] S_DST  = 2'd1;
   localparam logic [1:0] S_MODE = 2'd2;
   localparam logic [1:0] S_CIN  = 2'd3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] switches;
   logic [1:0]  selector;
   logic        push_button;
   logic        start_button;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [3:0]  alu_mode;
   logic        alu_cin;
   logic [15:0] alu_result;
   logic        alu_cout;
   logic [15:0] result;
   logic        carry_out;
   logic        result_valid;
   logic        busy;
   logic [3:0]  loaded;
   logic        start_err;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   logic [15:0] m_src, m_dst, m_res;
   logic [3:0]  m_mode, m_loaded;
   logic        m_cin, m_cout, m_rv, m_err;

   always #5 clk = ~clk;

   // ALU stub
   assign {alu_cout, alu_result} = 17'(alu_a) + 17'(alu_b) + 17'(alu_cin);

   alu_op_sequencer #(
      .DEBOUNCE_CYCLES (DEB),
      .SYNC_STAGES     (SYNC),
      .SETTLE_CYCLES   (SETTLE)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .switches     (switches),
      .selector     (selector),
      .push_button  (push_button),
      .start_button (start_button),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_mode     (alu_mode),
      .alu_cin      (alu_cin),
      .alu_result   (alu_result),
      .alu_cout     (alu_cout),
      .result       (result),
      .carry_out    (carry_out),
      .result_valid (result_valid),
      .busy         (busy),
      .loaded       (loaded),
      .start_err    (start_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_src = '0; m_dst = '0; m_mode = '0; m_cin = 1'b0;
      m_res = '0; m_cout = 1'b0; m_rv = 1'b0; m_err = 1'b0; m_loaded = '0;
   endtask

   // Model effect of an accepted start; returns expected busy length.
   task automatic model_start(output int exp_busy);
      logic [16:0] sum;
      if (m_loaded == 4'hF) begin
         sum      = {1'b0, m_src} + {1'b0, m_dst} + {16'd0, m_cin};
         m_res    = sum[15:0];
         m_cout   = sum[16];
         m_rv     = 1'b1;
         if (CHAIN) m_cin = sum[16];
         exp_busy = SETTLE + 1;
      end else begin
         m_err    = 1'b1;
         exp_busy = 0;
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".alu_a"},        32'(alu_a),        32'(m_src));
      check({tag, ".alu_b"},        32'(alu_b),        32'(m_dst));
      check({tag, ".alu_mode"},     32'(alu_mode),     32'(m_mode));
      check({tag, ".alu_cin"},      32'(alu_cin),      32'(m_cin));
      check({tag, ".result"},       32'(result),       32'(m_res));
      check({tag, ".carry_out"},    32'(carry_out),    32'(m_cout));
      check({tag, ".result_valid"}, 32'(result_valid), 32'(m_rv));
      check({tag, ".busy"},         32'(busy),         32'(0));
      check({tag, ".loaded"},       32'(loaded),       32'(m_loaded));
      check({tag, ".start_err"},    32'(start_err),    32'(m_err));
   endtask

   // Press and release the push button long enough for one accepted press.
   task automatic do_load(input logic [1:0] sel, input logic [15:0] sw);
      selector    = sel;
      switches    = sw;
      push_button = 1'b1;
      tick(10);
      push_button = 1'b0;
      tick(10);
      case (sel)
         S_SRC:  m_src  = sw;
         S_DST:  m_dst  = sw;
         S_MODE: m_mode = sw[3:0];
         S_CIN:  m_cin  = sw[0];
      endcase
      m_loaded[sel] = 1'b1;
      m_rv  = 1'b0;
      m_err = 1'b0;
   endtask

   // Press start, measure the busy window and the outputs where it ends.
   task automatic do_start(input string tag);
      int          busy_cycles;
      int          exp_busy;
      logic        prev_busy;
      logic        rv_at_fall;
      logic [15:0] res_at_fall;
      busy_cycles  = 0;
      prev_busy    = 1'b0;
      rv_at_fall   = 1'b0;
      res_at_fall  = '0;
      start_button = 1'b1;
      for (int i = 0; i < 40; i++) begin
         tick(1);
         if (i == 10) start_button = 1'b0;
         if (busy === 1'b1) busy_cycles++;
         if (prev_busy && busy === 1'b0) begin
            rv_at_fall  = result_valid;
            res_at_fall = result;
         end
         prev_busy = (busy === 1'b1);
      end
      model_start(exp_busy);
      check({tag, ".busy_cycles"}, 32'(busy_cycles), 32'(exp_busy));
      if (exp_busy != 0) begin
         check({tag, ".rv_at_fall"},  32'(rv_at_fall),  32'(1));
         check({tag, ".res_at_fall"}, 32'(res_at_fall), 32'(m_res));
      end
      check_all(tag);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          changes;
      logic [15:0] prev_a;
      logic        seen;
      logic        pushed;
      int          push_at;
      int          exp_busy;

      rst_n        = 1'b0;
      switches     = '0;
      selector     = '0;
      push_button  = 1'b0;
      start_button = 1'b0;
      model_reset();
      tick(3);
      check_all("reset");
      rst_n = 1'b1;
      tick(2);
      check_all("post_reset");

      // Start with only three registers loaded -> error, no operation.
      do_load(S_SRC,  16'h0101);
      do_load(S_DST,  16'h0202);
      do_load(S_MODE, 16'h0005);
      check("partial.loaded", 32'(loaded), 32'h7);
      do_start("start_early");
      check("start_early.err", 32'(start_err), 32'(1));
      do_load(S_CIN, 16'h0000);
      check_all("err_cleared");

      // Basic operation with upper mode/cin switch bits ignored.
      do_load(S_SRC,  16'h1234);
      do_load(S_DST,  16'h0F0F);
      do_load(S_MODE, 16'hFFF3);
      do_load(S_CIN,  16'h0001);
      check("basic.alu_mode", 32'(alu_mode), 32'h3);
      check("basic.alu_cin",  32'(alu_cin),  32'h1);
      check_all("basic_loaded");
      do_start("basic_op");
      check("basic.result", 32'(result), 32'h2144);

      // Bouncing push: three single-clock toggles, then a steady hold.
      // Switches change every clock so each load leaves a distinct value.
      selector = S_SRC;
      changes  = 0;
      prev_a   = alu_a;
      for (int i = 0; i < 30; i++) begin
         switches    = 16'h8000 | 16'(i);
         push_button = (i < 3) ? (i % 2 == 0) : (i < 13);
         tick(1);
         if (alu_a !== prev_a) changes++;
         prev_a = alu_a;
      end
      check("toggle.load_count", 32'(changes), 32'(1));
      check("toggle.src_msb",    32'(alu_a[15]), 32'(1));
      m_rv = 1'b0;
      do_load(S_SRC, 16'h1234);
      check_all("toggle_resync");

      // Carry-out and optional carry chaining.
      do_load(S_SRC, 16'hFFFF);
      do_load(S_DST, 16'h0001);
      do_load(S_CIN, 16'h0000);
      do_start("carry1");
      check("carry1.result", 32'(result),    32'h0000);
      check("carry1.cout",   32'(carry_out), 32'h1);
      do_start("carry2");

      // Push while busy is dropped.
      do_load(S_SRC, 16'h1111);
      do_load(S_CIN, 16'h0000);
      pushed       = 1'b0;
      push_at      = 0;
      start_button = 1'b1;
      for (int i = 0; i < 40; i++) begin
         tick(1);
         if (i == 10) start_button = 1'b0;
         if (busy === 1'b1 && !pushed) begin
            selector    = S_SRC;
            switches    = 16'hAAAA;
            push_button = 1'b1;
            pushed      = 1'b1;
            push_at     = i;
         end
         if (pushed && i == push_at + 10) push_button = 1'b0;
      end
      check("busy_push.seen", 32'(pushed), 32'(1));
      model_start(exp_busy);
      check("busy_push.alu_a", 32'(alu_a), 32'h1111);
      check_all("busy_push");

      // Reset in the middle of SETTLE aborts everything.
      start_button = 1'b1;
      seen         = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         tick(1);
         if (busy === 1'b1) seen = 1'b1;
      end
      check("rst_mid.busy_seen", 32'(seen), 32'(1));
      tick(3);
      rst_n        = 1'b0;
      start_button = 1'b0;
      #1;
      model_reset();
      check_all("reset_mid");
      tick(2);
      rst_n = 1'b1;
      tick(12);
      check_all("after_reset_mid");

      // Randomised loads and operations against the model.
      for (int it = 0; it < 12; it++) begin
         for (int s = 0; s < 4; s++) begin
            if (it == 0 || $urandom_range(0, 1) == 1)
               do_load(2'(s), 16'($urandom()));
         end
         check_all("rand_loaded");
         do_start("rand_op");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_alu_op_sequencer
